// File: rtl/inst_stage_sequencer_pkg.sv
// Shared constants, state encoding and opcode decode for the instruction stage sequencer.
// SEQ_MULTI_REG_EN enables PUSHM/POPM decode; without it they decode as plain single-stage instructions.
package inst_stage_sequencer_pkg;

  localparam logic [2:0] STAGE_KIND_NORMAL   = 3'd0;
  localparam logic [2:0] STAGE_KIND_PUSH_PC  = 3'd1;
  localparam logic [2:0] STAGE_KIND_PUSH_REG = 3'd2;
  localparam logic [2:0] STAGE_KIND_POP_REG  = 3'd3;
  localparam logic [2:0] STAGE_KIND_NOP      = 3'd4;

  localparam logic [9:0] OP_CALL  = 10'b0010000001;
  localparam logic [7:0] OP_PUSHM = 8'h1E;
  localparam logic [7:0] OP_POPM  = 8'h1F;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_CALL   = 2'd1,
    CLS_PUSHM  = 2'd2,
    CLS_POPM   = 2'd3
  } inst_cls_e;

  // Takes inst[15:6]; the PUSHM/POPM opcode is its upper byte.
  function automatic inst_cls_e decode_cls(input logic [9:0] hi10);
    inst_cls_e c;
    c = CLS_NORMAL;
    if (hi10 == OP_CALL) c = CLS_CALL;
`ifdef SEQ_MULTI_REG_EN
    else if (hi10[9:2] == OP_PUSHM) c = CLS_PUSHM;
    else if (hi10[9:2] == OP_POPM) c = CLS_POPM;
`endif
    return c;
  endfunction

endpackage

// File: rtl/inst_stage_sequencer_prio_enc.sv
// Priority encoder for the register mask: index of the first set bit (from MSB or LSB)
// plus flags for "any bit set" and "exactly one bit set".
module seq_prio_enc #(
  parameter int N = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_vec,
  output logic [IW-1:0] o_idx,
  output logic          o_any,
  output logic          o_single
);

  always_comb begin
    o_idx = '0;
    // Later hits overwrite earlier ones, so scan order decides the winner.
    for (int i = 0; i < N; i++) begin
      if (MSB_FIRST) begin
        if (i_vec[i]) o_idx = IW'(i);
      end else begin
        if (i_vec[N-1-i]) o_idx = IW'(N-1-i);
      end
    end
  end

  assign o_any    = |i_vec;
  assign o_single = o_any && ((i_vec & (i_vec - N'(1))) == '0);

endmodule

// File: rtl/inst_stage_sequencer.sv
// Expands one instruction into a sequence of stage descriptors (CALL, PUSHM/POPM, NORMAL).
// SEQ_MULTI_REG_EN enables the PUSHM/POPM register-mask expansion.
module inst_stage_sequencer
  import inst_stage_sequencer_pkg::*;
#(
  parameter int LOG2_NR   = 3,
  parameter int INST_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_inst_valid,
  input  logic [INST_BITS-1:0] i_inst,
  input  logic                 i_flush,
  input  logic                 i_stage_done,
  input  logic                 i_sc_next_imm,
  output logic                 o_busy,
  output logic [INST_BITS-1:0] o_inst_q,
  output logic                 o_stage_valid,
  output logic [2:0]           o_stage_kind,
  output logic [LOG2_NR-1:0]   o_stage_reg,
  output logic [LOG2_NR:0]     o_stage_index,
  output logic                 o_stage_first,
  output logic                 o_stage_last,
  output logic                 o_next_imm_data,
  output logic                 o_inst_done
);

  localparam logic [LOG2_NR:0] IDX_ONE = 1;

  seq_state_e           r_state, w_state_nxt;
  inst_cls_e            r_cls;
  logic [INST_BITS-1:0] r_inst_q;
  logic [LOG2_NR:0]     r_index;
  logic                 w_accept, w_advance;

`ifdef SEQ_MULTI_REG_EN
  localparam int NR = 1 << LOG2_NR;
  logic [NR-1:0]      r_mask;
  logic [LOG2_NR-1:0] w_hi_idx, w_lo_idx;
  logic               w_hi_any, w_lo_any, w_hi_single, w_lo_single;
  logic               w_any, w_single;

  seq_prio_enc #(.N(NR), .MSB_FIRST(1'b1)) u_enc_hi (
    .i_vec(r_mask), .o_idx(w_hi_idx), .o_any(w_hi_any), .o_single(w_hi_single)
  );
  seq_prio_enc #(.N(NR), .MSB_FIRST(1'b0)) u_enc_lo (
    .i_vec(r_mask), .o_idx(w_lo_idx), .o_any(w_lo_any), .o_single(w_lo_single)
  );

  assign w_any    = (r_cls == CLS_PUSHM) ? w_hi_any    : w_lo_any;
  assign w_single = (r_cls == CLS_PUSHM) ? w_hi_single : w_lo_single;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_inst_valid && !i_flush) w_state_nxt = ST_RUN;
      ST_RUN:  if (i_flush || (i_stage_done && o_stage_last)) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_stage_valid = 1'b0;
    o_stage_kind  = STAGE_KIND_NORMAL;
    o_stage_reg   = '0;
    o_stage_index = '0;
    o_stage_first = 1'b0;
    o_stage_last  = 1'b0;
    if (r_state == ST_RUN) begin
      o_stage_valid = 1'b1;
      o_stage_index = r_index;
      o_stage_first = (r_index == '0);
      case (r_cls)
        CLS_CALL: begin
          o_stage_kind = (r_index == '0) ? STAGE_KIND_PUSH_PC : STAGE_KIND_NORMAL;
          o_stage_last = (r_index != '0);
        end
`ifdef SEQ_MULTI_REG_EN
        CLS_PUSHM, CLS_POPM: begin
          // The mask is only empty while running if it was accepted empty.
          if (w_any) begin
            o_stage_kind = (r_cls == CLS_PUSHM) ? STAGE_KIND_PUSH_REG : STAGE_KIND_POP_REG;
            o_stage_reg  = (r_cls == CLS_PUSHM) ? w_hi_idx : w_lo_idx;
            o_stage_last = w_single;
          end else begin
            o_stage_kind = STAGE_KIND_NOP;
            o_stage_last = 1'b1;
          end
        end
`endif
        default: o_stage_last = 1'b1;
      endcase
    end
  end

  assign o_busy          = (r_state == ST_RUN);
  assign o_inst_q        = r_inst_q;
  assign o_next_imm_data = i_sc_next_imm && o_stage_valid && o_stage_last;
  assign o_inst_done     = o_stage_valid && i_stage_done && o_stage_last && !i_flush;

  assign w_accept  = (r_state == ST_IDLE) && i_inst_valid && !i_flush;
  assign w_advance = (r_state == ST_RUN) && i_stage_done && !i_flush && !o_stage_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_inst_q <= '0;
      r_cls    <= CLS_NORMAL;
      r_index  <= '0;
    end else if (w_accept) begin
      r_inst_q <= i_inst;
      r_cls    <= decode_cls(i_inst[15:6]);
      r_index  <= '0;
    end else if (w_advance) begin
      r_index  <= r_index + IDX_ONE;
    end
  end

`ifdef SEQ_MULTI_REG_EN
  always_ff @(posedge clk) begin
    if (reset) r_mask <= '0;
    else if (w_accept) r_mask <= i_inst[NR-1:0];
    else if (w_advance && (r_cls == CLS_PUSHM || r_cls == CLS_POPM)) r_mask[o_stage_reg] <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_inst_stage_sequencer.sv
// Self-checking bench for inst_stage_sequencer: vector table driven through a descriptor
// scoreboard, plus hand sequences for flush, back-to-back accept and mid-operation reset.
module tb_inst_stage_sequencer;
  import inst_stage_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_inst_valid, i_flush, i_stage_done, i_sc_next_imm;
  logic [15:0] i_inst;
  logic        o_busy, o_stage_valid, o_stage_first, o_stage_last, o_next_imm_data, o_inst_done;
  logic [15:0] o_inst_q;
  logic [2:0]  o_stage_kind, o_stage_reg;
  logic [3:0]  o_stage_index;

  int checks = 0;
  int failures = 0;

  inst_stage_sequencer #(.LOG2_NR(3), .INST_BITS(16)) dut (
    .clk(clk), .reset(reset), .i_inst_valid(i_inst_valid), .i_inst(i_inst),
    .i_flush(i_flush), .i_stage_done(i_stage_done), .i_sc_next_imm(i_sc_next_imm),
    .o_busy(o_busy), .o_inst_q(o_inst_q), .o_stage_valid(o_stage_valid),
    .o_stage_kind(o_stage_kind), .o_stage_reg(o_stage_reg), .o_stage_index(o_stage_index),
    .o_stage_first(o_stage_first), .o_stage_last(o_stage_last),
    .o_next_imm_data(o_next_imm_data), .o_inst_done(o_inst_done)
  );

  always #5 clk = ~clk;

  // rg holds the per-stage register numbers, stage 0 in the rightmost field.
  typedef struct {
    logic [15:0]     inst;
    int              nst;
    logic [2:0]      k0;
    logic [2:0]      kr;
    logic [7:0][2:0] rg;
  } vec_t;

  typedef struct {
    logic [2:0] kind;
    logic [2:0] rg;
    logic [3:0] idx;
    logic       first;
    logic       last;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v, input bit imm);
    exp_t e;
    int   stall;
    i_inst = v.inst;
    i_inst_valid = 1'b1;
    i_sc_next_imm = imm;
    for (int k = 0; k < v.nst; k++) begin
      e.kind  = (k == 0) ? v.k0 : v.kr;
      e.rg    = v.rg[k];
      e.idx   = 4'(k);
      e.first = (k == 0);
      e.last  = (k == v.nst - 1);
      sb.push_back(e);
    end
    @(negedge clk);
    chk("accept_latency", o_stage_valid, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      stall = $urandom_range(0, 1);
      for (int s = 0; s <= stall; s++) begin
        if (s > 0) @(negedge clk);
        chk("kind", o_stage_kind, e.kind);
        chk("reg", o_stage_reg, e.rg);
        chk("index", o_stage_index, e.idx);
        chk("first", o_stage_first, e.first);
        chk("last", o_stage_last, e.last);
        chk("next_imm", o_next_imm_data, imm & e.last);
        chk("inst_q", o_inst_q, v.inst);
      end
      i_stage_done = 1'b1;
      #1;
      chk("inst_done", o_inst_done, e.last);
      @(negedge clk);
      i_stage_done = 1'b0;
      if (e.last) i_inst_valid = 1'b0;
    end
    chk("busy_after_done", o_busy, 0);
    chk("valid_after_done", o_stage_valid, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_inst_q"}, o_inst_q, 0);
    chk({tag, "_valid"}, o_stage_valid, 0);
    chk({tag, "_kind"}, o_stage_kind, 0);
    chk({tag, "_reg"}, o_stage_reg, 0);
    chk({tag, "_index"}, o_stage_index, 0);
    chk({tag, "_first"}, o_stage_first, 0);
    chk({tag, "_last"}, o_stage_last, 0);
    chk({tag, "_imm"}, o_next_imm_data, 0);
    chk({tag, "_done"}, o_inst_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   npre;
    vec_t v;

    vecs[0] = '{16'h8123, 1, STAGE_KIND_NORMAL, STAGE_KIND_NORMAL, '0};
    vecs[1] = '{16'h2045, 2, STAGE_KIND_PUSH_PC, STAGE_KIND_NORMAL, '0};
    vecs[6] = '{16'h207F, 2, STAGE_KIND_PUSH_PC, STAGE_KIND_NORMAL, '0};
    vecs[7] = '{16'h203F, 1, STAGE_KIND_NORMAL, STAGE_KIND_NORMAL, '0};
`ifdef SEQ_MULTI_REG_EN
    vecs[2] = '{16'h1EA5, 4, STAGE_KIND_PUSH_REG, STAGE_KIND_PUSH_REG,
                {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd5, 3'd7}};
    vecs[3] = '{16'h1FA5, 4, STAGE_KIND_POP_REG, STAGE_KIND_POP_REG,
                {3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd5, 3'd2, 3'd0}};
    vecs[4] = '{16'h1E00, 1, STAGE_KIND_NOP, STAGE_KIND_NOP, '0};
    vecs[5] = '{16'h1F80, 1, STAGE_KIND_POP_REG, STAGE_KIND_POP_REG, {21'd0, 3'd7}};
`else
    vecs[2] = '{16'h1EA5, 1, STAGE_KIND_NORMAL, STAGE_KIND_NORMAL, '0};
    vecs[3] = '{16'h1FA5, 1, STAGE_KIND_NORMAL, STAGE_KIND_NORMAL, '0};
    vecs[4] = '{16'h1E00, 1, STAGE_KIND_NORMAL, STAGE_KIND_NORMAL, '0};
    vecs[5] = '{16'h1F80, 1, STAGE_KIND_NORMAL, STAGE_KIND_NORMAL, '0};
`endif

    reset = 1'b1;
    i_inst_valid = 1'b0; i_inst = '0; i_flush = 1'b0;
    i_stage_done = 1'b0; i_sc_next_imm = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_all_zero("reset");

    for (int i = 0; i < 8; i++) run_vec(vecs[i], 1'b1);
    run_vec(vecs[1], 1'b0);
    run_vec(vecs[3], 1'b0);

    // Flush and stray stage_done while idle must not start anything.
    i_inst = 16'h8123; i_inst_valid = 1'b1; i_flush = 1'b1;
    @(negedge clk);
    chk("idle_flush_busy", o_busy, 0);
    i_flush = 1'b0; i_inst_valid = 1'b0; i_stage_done = 1'b1;
    #1;
    chk("idle_done_pulse", o_inst_done, 0);
    @(negedge clk);
    i_stage_done = 1'b0;
    chk("idle_done_valid", o_stage_valid, 0);

    // Flush together with stage_done on the third PUSHM stage.
`ifdef SEQ_MULTI_REG_EN
    npre = 2;
`else
    npre = 0;
`endif
    i_inst = 16'h1EFF; i_inst_valid = 1'b1; i_sc_next_imm = 1'b1;
    @(negedge clk);
    repeat (npre) begin
      i_stage_done = 1'b1;
      @(negedge clk);
    end
    chk("flush_stage_index", o_stage_index, npre);
`ifdef SEQ_MULTI_REG_EN
    chk("flush_stage_reg", o_stage_reg, 5);
`else
    chk("flush_stage_reg", o_stage_reg, 0);
`endif
    i_stage_done = 1'b1; i_flush = 1'b1;
    #1;
    chk("flush_no_done", o_inst_done, 0);
    @(negedge clk);
    i_stage_done = 1'b0; i_flush = 1'b0; i_inst_valid = 1'b0;
    chk("flush_valid", o_stage_valid, 0);
    chk("flush_busy", o_busy, 0);
    v = '{16'h8000, 1, STAGE_KIND_NORMAL, STAGE_KIND_NORMAL, '0};
    run_vec(v, 1'b1);

    // Back-to-back: inst_done at n, next accepted at n+1, stage_valid at n+2.
    i_inst = 16'h8123; i_inst_valid = 1'b1;
    @(negedge clk);
    i_stage_done = 1'b1;
    #1;
    chk("b2b_done", o_inst_done, 1);
    i_inst = 16'h8456;
    @(negedge clk);
    i_stage_done = 1'b0;
    chk("b2b_gap_valid", o_stage_valid, 0);
    @(negedge clk);
    chk("b2b_valid", o_stage_valid, 1);
    chk("b2b_inst_q", o_inst_q, 16'h8456);
    chk("b2b_index", o_stage_index, 0);
    i_inst_valid = 1'b0; i_stage_done = 1'b1;
    @(negedge clk);
    i_stage_done = 1'b0;
    chk("b2b_end_busy", o_busy, 0);

    // Reset while a POPM sits on its third stage.
    i_inst = 16'h1FA5; i_inst_valid = 1'b1;
    @(negedge clk);
    repeat (npre) begin
      i_stage_done = 1'b1;
      @(negedge clk);
    end
    i_stage_done = 1'b0;
    chk("prereset_busy", o_busy, 1);
`ifdef SEQ_MULTI_REG_EN
    chk("prereset_reg", o_stage_reg, 5);
`endif
    reset = 1'b1; i_inst_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk_all_zero("midreset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
